alu_op_driver: RTL and testbench
================================

// Module: alu_op_driver
// PURPOSE
//  Command-side initiator for the 4-mode 8-bit ALU (modes 0 add, 1 sub, 2 mul, 3 mod).
//  The ALU has no mode output, so this block keeps a shadow copy of its mode.
//  It accepts {op,a,b} commands over valid/ready and drives the operands.
//  It pulses the ALU advance strobe until the ALU is in the requested mode, captures the 32-bit result,
//  and returns it over valid/ready. It shares clk/rst with the ALU.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles waited in the target mode before sampling alu_out; legal range 1..15.
// PORTS
//  clk        in   1   clock; all logic is on the rising edge.
//  rst        in   1   reset: synchronous, active-low; same net as the ALU reset.
//  cmd_valid  in   1   command present.
//  cmd_ready  out  1   block can accept a command (high only in IDLE).
//  cmd_op     in   2   requested mode: 0 add, 1 sub, 2 mul, 3 mod.
//  cmd_a      in   8   operand A.
//  cmd_b      in   8   operand B.
//  alu_a      out  8   operand A to the ALU (registered).
//  alu_b      out  8   operand B to the ALU (registered).
//  alu_s      out  1   ALU mode-advance strobe.
//  alu_out    in   32  ALU result.
//  rsp_valid  out  1   response present.
//  rsp_ready  in   1   consumer accepts the response.
//  rsp_data   out  32  captured result.
//  rsp_op     out  2   echo of the command's op.
//  rsp_err    out  1   set for mod by zero.
//  alu_mode   out  2   shadow ALU mode (debug).
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - state=IDLE, mode=0, alu_a=alu_b=0, rsp_data=0, rsp_op=0, rsp_err=0, rsp_valid=0.
//   - This also applies mid-operation; any in-flight command is dropped.
//   - The ALU resets to mode 0 on the same edge, so the shadow stays consistent.
//  FSM states: IDLE, STEP, SETTLE, RESP.
//  IDLE:
//   - cmd_ready=1.
//   - On cmd_valid&cmd_ready: latch op; alu_a<=cmd_a, alu_b<=cmd_b; steps<=(op-mode) mod 4 (2-bit wrap).
//   - Next state is STEP if steps!=0, else SETTLE. Settle counter loads SETTLE_CYCLES.
//  STEP:
//   - alu_s=1, decoded from the state register (no other state drives it).
//   - Each edge: mode<=mode+1 (wraps 3->0), steps<=steps-1.
//   - Go to SETTLE on the edge where steps==1.
//   - alu_s is therefore high for exactly `steps` consecutive cycles.
//  SETTLE:
//   - alu_s=0; count down from SETTLE_CYCLES.
//   - On the final edge:
//     - normal case: rsp_data<=alu_out, rsp_err<=0;
//     - op==3 with alu_b==0: rsp_data<=0, rsp_err<=1 (ALU mod-by-zero output is undefined);
//     - rsp_op<=op; go to RESP.
//  RESP:
//   - rsp_valid=1; rsp_data, rsp_op and rsp_err are held stable until rsp_ready=1.
//   - On the edge where rsp_valid&rsp_ready: go to IDLE.
//   - rsp_data is not cleared; cmd_ready returns to 1 in the next cycle. No response/command overlap.
//  cmd_ready=0 outside IDLE. cmd_valid is ignored while busy; the command must be held by its source.
//  Latency: rsp_valid rises steps+SETTLE_CYCLES edges after the accept edge.
//   - Minimum is 1 (same mode). Maximum is 3+SETTLE_CYCLES.
//  Width: alu_out is passed through unmodified. Sub is 32-bit two's complement (3-5 = 32'hFFFF_FFFE).
//  alu_a and alu_b hold their value from one accept to the next.
//  Mode is never changed except in STEP or by reset.
// TESTING
//  1 reset; op0 a=20 b=22 -> no alu_s pulse; rsp_data=42 one cycle after accept; alu_mode=0.
//  2 from mode 0: op2 a=15 b=17 -> alu_s high exactly 2 cycles; rsp_data=255; alu_mode=2.
//  3 from mode 2: op1 a=3 b=5 -> 3 alu_s cycles (2->3->0->1); rsp_data=32'hFFFF_FFFE; rsp_op=1.
//  4 op3 a=100 b=0 -> rsp_err=1, rsp_data=0; then op3 a=100 b=7 -> rsp_err=0, rsp_data=2, no alu_s pulse.
//  5 rsp_ready low 5 cycles with cmd_valid high -> rsp_* stable, cmd_ready=0, second cmd accepted only after handshake.
//  6 rst=0 during STEP -> next cycle: IDLE, alu_s=0, alu_mode=0, rsp_valid=0, alu_a=alu_b=0; then op0 works (test 1).

Source files
------------

// File: rtl/alu_op_driver.sv
// rtl/alu_op_driver.sv - command-side driver for the 4-mode 8-bit ALU
module alu_op_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_s,
    input  logic [31:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_err,
    output logic [1:0]  alu_mode
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STEP   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] OP_MOD      = 2'd3;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [1:0] mode;
    logic [1:0] steps;
    logic [1:0] op;
    logic [3:0] settle_cnt;
    logic       mod_by_zero;

    assign cmd_ready   = (state == IDLE);
    assign alu_s       = (state == STEP);
    assign rsp_valid   = (state == RESP);
    assign alu_mode    = mode;
    assign mod_by_zero = (op == OP_MOD) && (alu_b == 8'd0);

    // mode shadows the ALU, which resets on the same edge and advances on every alu_s cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mode       <= 2'd0;
            steps      <= 2'd0;
            op         <= 2'd0;
            settle_cnt <= 4'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            rsp_data   <= 32'd0;
            rsp_op     <= 2'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op         <= cmd_op;
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        steps      <= cmd_op - mode;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= (cmd_op != mode) ? STEP : SETTLE;
                    end
                end
                STEP: begin
                    mode  <= mode + 2'd1;
                    steps <= steps - 2'd1;
                    if (steps == 2'd1) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd1) begin
                        // the ALU's mod-by-zero output is undefined, so report an error instead
                        if (mod_by_zero) begin
                            rsp_data <= 32'd0;
                            rsp_err  <= 1'b1;
                        end else begin
                            rsp_data <= alu_out;
                            rsp_err  <= 1'b0;
                        end
                        rsp_op <= op;
                        state  <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// tb/tb_alu_op_driver.sv - scoreboard bench for alu_op_driver with a behavioural ALU
module tb_alu_op_driver;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_s;
    logic [31:0] alu_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_err;
    logic [1:0]  alu_mode;

    alu_op_driver #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .alu_mode(alu_mode)
    );

    always #5 clk = ~clk;

    // external ALU: mode register stepped by alu_s, combinational result
    logic [1:0] ext_mode = 2'd0;
    always @(posedge clk) begin
        if (!rst) ext_mode <= 2'd0;
        else if (alu_s) ext_mode <= ext_mode + 2'd1;
    end
    always_comb begin
        alu_out = 32'd0;
        case (ext_mode)
            2'd0: alu_out = 32'(alu_a) + 32'(alu_b);
            2'd1: alu_out = 32'(alu_a) - 32'(alu_b);
            2'd2: alu_out = 32'(alu_a) * 32'(alu_b);
            default: alu_out = (alu_b == 8'd0) ? 32'hDEAD_BEEF : 32'(alu_a) % 32'(alu_b);
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] data;
        logic        err;
        int          steps;
        int          acc;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] tb_mode = 2'd0;
    bit         force_low = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        case (op)
            2'd0: return ua + ub;
            2'd1: return ua - ub;
            2'd2: return ua * ub;
            default: return (ub == 0) ? 32'd0 : ua % ub;
        endcase
    endfunction

    // monitor: samples 1 time unit after each rising edge
    logic        last_valid = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_op;
    logic        held_err;
    int          pulses = 0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            pulses = 0;
            last_valid = 1'b0;
        end else begin
            if (alu_s) pulses++;
            if (rsp_valid && !last_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%h required=none", rsp_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_op", 32'(rsp_op), 32'(e.op));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("alu_s_pulses", 32'(pulses), 32'(e.steps));
                    check("latency", 32'(cyc - e.acc), 32'(e.steps + SETTLE));
                    check("alu_mode", 32'(alu_mode), 32'(e.op));
                    check("alu_a", 32'(alu_a), 32'(e.a));
                    check("alu_b", 32'(alu_b), 32'(e.b));
                end
                pulses = 0;
                held_data = rsp_data;
                held_op = rsp_op;
                held_err = rsp_err;
            end else if (last_valid) begin
                if (!rsp_ready) begin
                    check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                    check("rsp_hold_data", rsp_data, held_data);
                    check("rsp_hold_op", 32'(rsp_op), 32'(held_op));
                    check("rsp_hold_err", 32'(rsp_err), 32'(held_err));
                    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                end else begin
                    check("rsp_drop", 32'(rsp_valid), 32'd0);
                end
            end
            last_valid = rsp_valid;
        end
    end

    task automatic present(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        exp_t e;
        for (int n = 0; n < 200 && !cmd_ready; n++) @(negedge clk);
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d required=1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        check("no_overlap", 32'(rsp_valid), 32'd0);
        e.op = cmd_op;
        e.a = cmd_a;
        e.b = cmd_b;
        e.data = ref_result(cmd_op, cmd_a, cmd_b);
        e.err = (cmd_op == 2'd3) && (cmd_b == 8'd0);
        e.steps = (int'(cmd_op) - int'(tb_mode) + 4) % 4;
        e.acc = cyc + 1;
        sbq.push_back(e);
        tb_mode = cmd_op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        present(op, a, b);
        wait_accept();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && (sbq.size() != 0 || !cmd_ready); n++) @(negedge clk);
        if (sbq.size() != 0 || !cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_alu_s"}, 32'(alu_s), 32'd0);
        check({tag, "_alu_mode"}, 32'(alu_mode), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        force_low = 1'b0;
        @(negedge clk);

        send(2'd0, 8'd20, 8'd22);
        wait_idle();
        send(2'd2, 8'd15, 8'd17);
        wait_idle();
        send(2'd1, 8'd3, 8'd5);
        wait_idle();
        send(2'd3, 8'd100, 8'd0);
        wait_idle();
        send(2'd3, 8'd100, 8'd7);
        wait_idle();

        // back-pressure with a second command waiting
        force_low = 1'b1;
        send(2'd0, 8'd1, 8'd2);
        present(2'd1, 8'd9, 8'd4);
        for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("cmd_ready_stall", 32'(cmd_ready), 32'd0);
        end
        force_low = 1'b0;
        wait_accept();
        wait_idle();

        // reset while stepping
        send(2'd0, 8'd5, 8'd6);
        for (int n = 0; n < 20 && !alu_s; n++) @(negedge clk);
        check("step_seen", 32'(alu_s), 32'd1);
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b1;
        tb_mode = 2'd0;
        send(2'd0, 8'd20, 8'd22);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            logic [1:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(op, a, b);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
